// File: rtl/fcmp_pkg.sv
// fcmp_pkg: shared op encoding, payload type and latency limits for the compare pipeline
package fcmp_pkg;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam int TAG_DEF = 4;
  typedef enum logic [1:0] {
    OP_FEQ = 2'b00,
    OP_FLT = 2'b01,
    OP_FLE = 2'b10,
    OP_RSV = 2'b11
  } op_e;
  typedef struct packed {
    logic               result;
    logic               invalid;
    logic [TAG_DEF-1:0] tag;
  } stage_t;
endpackage

// File: rtl/fcmp_stage.sv
// fcmp_stage: one valid/ready register slice carrying a compare payload
module fcmp_stage
  import fcmp_pkg::*;
#(
  parameter type T = stage_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_valid,
  input  T     i_data,
  output logic o_valid,
  output T     o_data,
  input  logic o_ready
);
  logic r_valid;
  T     r_data;
  logic w_load;
  assign w_load  = !r_valid || o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  // Refill whenever the slot is free or draining; the payload only moves on a real load so it holds under stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
endmodule

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: pipelined IEEE-style FEQ/FLT/FLE comparator with tag pass-through and valid/ready flow control
module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     x1,
  input  logic [EXP_W+MAN_W:0]     x2,
  input  logic [1:0]               op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     result,
  output logic                     invalid,
  output logic [TAG_W-1:0]         out_tag
);
  localparam int W = 1 + EXP_W + MAN_W;
  typedef struct packed {
    logic             result;
    logic             invalid;
    logic [TAG_W-1:0] tag;
  } pay_t;

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
    $error("fcmp_pipe: LATENCY must be within 1..4");
  end

  logic         r_rdy;
  logic         w_s1, w_s2, w_z1, w_z2, w_nan1, w_nan2, w_eq, w_lt, w_bad;
  logic [W-2:0] w_m1, w_m2;
  op_e          w_op;
  pay_t         w_in;
  logic [LATENCY:0] w_v;
  pay_t         w_d [LATENCY+1];

  // Sign-magnitude ordering: magnitudes compare as unsigned integers, negatives invert the sense
  assign w_s1   = x1[W-1];
  assign w_s2   = x2[W-1];
  assign w_m1   = x1[W-2:0];
  assign w_m2   = x2[W-2:0];
  assign w_z1   = ~|w_m1;
  assign w_z2   = ~|w_m2;
  assign w_nan1 = (&x1[W-2:MAN_W]) && (|x1[MAN_W-1:0]);
  assign w_nan2 = (&x2[W-2:MAN_W]) && (|x2[MAN_W-1:0]);
  assign w_op   = op_e'(op);
  assign w_eq   = (x1 == x2) || (w_z1 && w_z2);
  assign w_lt   = !w_eq && ((w_s1 && !w_s2) || (!w_s1 && !w_s2 && (w_m1 < w_m2)) || (w_s1 && w_s2 && (w_m1 > w_m2)));
  assign w_bad  = w_nan1 || w_nan2 || (w_op == OP_RSV);

  // Stage-1 payload: NaN or reserved op forces result low and flags invalid
  always_comb begin
    w_in         = '0;
    w_in.invalid = w_bad;
    w_in.result  = !w_bad && (w_op == OP_FEQ ? w_eq : w_op == OP_FLT ? w_lt : (w_lt || w_eq));
    w_in.tag     = in_tag;
  end

  // Holds in_ready low through reset and releases it on the first clock after
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rdy <= 1'b0;
    else       r_rdy <= 1'b1;
  end

  assign w_v[0] = in_valid && r_rdy;
  assign w_d[0] = w_in;
  assign in_ready = r_rdy && (out_ready || !(&w_v[LATENCY:1]));

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    logic w_dn;
    if (g == LATENCY - 1) begin : g_last
      assign w_dn = out_ready;
    end else begin : g_mid
      assign w_dn = out_ready || !(&w_v[LATENCY:g+2]);
    end
    fcmp_stage #(.T(pay_t)) u_stage (
      .clk     (clk),
      .rstn    (rstn),
      .i_valid (w_v[g]),
      .i_data  (w_d[g]),
      .o_valid (w_v[g+1]),
      .o_data  (w_d[g+1]),
      .o_ready (w_dn)
    );
  end

  assign out_valid = w_v[LATENCY];
  assign result    = w_d[LATENCY].result;
  assign invalid   = w_d[LATENCY].invalid;
  assign out_tag   = w_d[LATENCY].tag;
endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: directed checks of compare function, streaming, backpressure and reset behaviour
module tb_fcmp_pipe;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        iv_a = 0, ir_a, ov_a, or_a = 0, res_a, inv_a;
  logic [31:0] x1_a = 0, x2_a = 0;
  logic [1:0]  op_a = 0;
  logic [3:0]  tag_a = 0, otag_a;
  logic        iv_b = 0, ir_b, ov_b, or_b = 0, res_b, inv_b;
  logic [31:0] x1_b = 0, x2_b = 0;
  logic [1:0]  op_b = 0;
  logic [3:0]  tag_b = 0, otag_b;

  int errors = 0;
  int checks = 0;

  fcmp_pipe #(.LATENCY(2)) u_a (
    .clk(clk), .rstn(rstn), .in_valid(iv_a), .in_ready(ir_a), .x1(x1_a), .x2(x2_a),
    .op(op_a), .in_tag(tag_a), .out_valid(ov_a), .out_ready(or_a), .result(res_a),
    .invalid(inv_a), .out_tag(otag_a)
  );

  fcmp_pipe #(.LATENCY(3)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(iv_b), .in_ready(ir_b), .x1(x1_b), .x2(x2_b),
    .op(op_b), .in_tag(tag_b), .out_valid(ov_b), .out_ready(or_b), .result(res_b),
    .invalid(inv_b), .out_tag(otag_b)
  );

  task automatic send_a(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        output logic r, output logic inv, output logic [3:0] tg, output bit to);
    @(negedge clk);
    op_a = o; x1_a = a; x2_a = b; tag_a = t; iv_a = 1; or_a = 1;
    @(posedge clk);
    #1 iv_a = 0;
    to = 1; r = 0; inv = 0; tg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov_a) begin
        r = res_a; inv = inv_a; tg = otag_a; to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rstn = 0;
    #2;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", ov_a); end
    checks++; if (res_a !== 1'b0) begin errors++; $display("FAIL reset_result got=%b want=0", res_a); end
    checks++; if (inv_a !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b want=0", inv_a); end
    checks++; if (otag_a !== 4'h0) begin errors++; $display("FAIL reset_out_tag got=%h want=0", otag_a); end
    checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", ir_a); end
    checks++; if (ir_b !== 1'b0) begin errors++; $display("FAIL reset_in_ready_b got=%b want=0", ir_b); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got=%b want=0", ir_a); end
    @(posedge clk);
    #1;
    checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", ir_a); end
  endtask

  task automatic test_vectors;
    logic [67:0] v [21];
    logic r, inv;
    logic [3:0] tg;
    bit to;
    v = '{
      {2'b10, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0},
      {2'b01, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0},
      {2'b00, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0},
      {2'b01, 32'hBF800000, 32'h3F800000, 1'b1, 1'b0},
      {2'b01, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0},
      {2'b01, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0},
      {2'b01, 32'h00000001, 32'h00000002, 1'b1, 1'b0},
      {2'b01, 32'h80000001, 32'h00000000, 1'b1, 1'b0},
      {2'b01, 32'h80000000, 32'h00000001, 1'b1, 1'b0},
      {2'b01, 32'h00000000, 32'h80000000, 1'b0, 1'b0},
      {2'b10, 32'h00000000, 32'h80000000, 1'b1, 1'b0},
      {2'b00, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0},
      {2'b01, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0},
      {2'b01, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0},
      {2'b10, 32'h7F800001, 32'h7F800001, 1'b0, 1'b1},
      {2'b00, 32'h3F800000, 32'hFF800001, 1'b0, 1'b1},
      {2'b10, 32'h00700000, 32'h00400000, 1'b0, 1'b0},
      {2'b10, 32'h005FFFFF, 32'h007FFFFF, 1'b1, 1'b0},
      {2'b10, 32'h807FFFFF, 32'h80000001, 1'b1, 1'b0},
      {2'b00, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0},
      {2'b10, 32'h40490FDB, 32'h40490FDA, 1'b0, 1'b0}
    };
    for (int i = 0; i < 21; i++) begin
      send_a(v[i][67:66], v[i][65:34], v[i][33:2], 4'(i), r, inv, tg, to);
      checks++;
      if (to) begin errors++; $display("FAIL vec%0d_timeout no out_valid within bound", i); end
      else if ({r, inv, tg} !== {v[i][1], v[i][0], 4'(i)})
        begin errors++; $display("FAIL vec%0d got res=%b inv=%b tag=%h want res=%b inv=%b tag=%h", i, r, inv, tg, v[i][1], v[i][0], 4'(i)); end
    end
  endtask

  task automatic test_zero_nan;
    logic r, inv;
    logic [3:0] tg;
    bit to;
    send_a(2'b00, 32'h80000000, 32'h00000000, 4'h3, r, inv, tg, to);
    checks++; if (to || r !== 1'b1 || inv !== 1'b0) begin errors++; $display("FAIL feq_zeros got res=%b inv=%b to=%0d want res=1 inv=0", r, inv, to); end
    send_a(2'b01, 32'h7FC00000, 32'h3F800000, 4'h4, r, inv, tg, to);
    checks++; if (to || r !== 1'b0 || inv !== 1'b1) begin errors++; $display("FAIL flt_nan got res=%b inv=%b to=%0d want res=0 inv=1", r, inv, to); end
  endtask

  task automatic test_reserved;
    logic r, inv;
    logic [3:0] tg;
    bit to;
    send_a(2'b11, 32'h3F800000, 32'h3F800000, 4'hA, r, inv, tg, to);
    checks++; if (to || r !== 1'b0 || inv !== 1'b1) begin errors++; $display("FAIL reserved_op got res=%b inv=%b to=%0d want res=0 inv=1", r, inv, to); end
    checks++; if (tg !== 4'hA) begin errors++; $display("FAIL reserved_tag got=%h want=a", tg); end
  endtask

  task automatic test_sweep;
    logic [22:0] mans [7];
    logic [7:0] ex [2];
    logic r, inv, e;
    logic [3:0] tg;
    bit to;
    mans = '{23'h000000, 23'h000001, 23'h000002, 23'h400000, 23'h5FFFFF, 23'h700000, 23'h7FFFFF};
    ex = '{8'd0, 8'd127};
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 7; j++)
          for (int s = 0; s < 4; s++) begin
            e = s == 0 ? (i <= j) : s == 1 ? (j <= i) : s == 2 ? 1'b1 : (k == 0 && i == 0 && j == 0);
            send_a(2'b10, {s == 1 || s == 2, ex[k], mans[i]}, {s == 1 || s == 3, ex[k], mans[j]}, 4'(s), r, inv, tg, to);
            checks++;
            if (to || {r, inv} !== {e, 1'b0})
              begin errors++; $display("FAIL sweep_man e=%0d i=%0d j=%0d s=%0d got res=%b inv=%b to=%0d want res=%b", ex[k], i, j, s, r, inv, to, e); end
          end
    for (int x = 0; x < 254; x++)
      for (int s = 0; s < 3; s++) begin
        e = (s != 1);
        if (s == 0) send_a(2'b10, {1'b0, 8'(x), 23'h7FFFFF}, {1'b0, 8'(x + 1), 23'h0}, 4'(s), r, inv, tg, to);
        else if (s == 1) send_a(2'b10, {1'b0, 8'(x + 1), 23'h0}, {1'b0, 8'(x), 23'h7FFFFF}, 4'(s), r, inv, tg, to);
        else send_a(2'b10, {1'b1, 8'(x + 1), 23'h0}, {1'b1, 8'(x), 23'h7FFFFF}, 4'(s), r, inv, tg, to);
        checks++;
        if (to || {r, inv} !== {e, 1'b0})
          begin errors++; $display("FAIL sweep_exp e=%0d s=%0d got res=%b inv=%b to=%0d want res=%b", x, s, r, inv, to, e); end
      end
  endtask

  task automatic test_back_to_back;
    logic ev;
    or_b = 1; op_b = 2'b00; x1_b = 32'h3F800000; x2_b = 32'h3F800000;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      ev = (k >= 3 && k <= 10);
      checks++; if (ov_b !== ev) begin errors++; $display("FAIL stream_valid k=%0d got=%b want=%b", k, ov_b, ev); end
      if (ev) begin
        checks++;
        if (otag_b !== 4'(k - 3) || res_b !== 1'b1) begin errors++; $display("FAIL stream_tag k=%0d got tag=%h res=%b want tag=%h res=1", k, otag_b, res_b, 4'(k - 3)); end
      end
      iv_b = (k < 8); tag_b = 4'(k);
      #1;
      if (k < 8) begin
        checks++; if (ir_b !== 1'b1) begin errors++; $display("FAIL stream_ready k=%0d got=%b want=1", k, ir_b); end
      end
    end
    iv_b = 0;
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if ({ov_a, otag_a, res_a, inv_a} !== {1'b1, 4'h5, 1'b1, 1'b0})
          begin errors++; $display("FAIL bp_hold k=%0d got v=%b tag=%h res=%b inv=%b want v=1 tag=5 res=1 inv=0", k, ov_a, otag_a, res_a, inv_a); end
      end
      checks++; if (ir_a !== (k < 2)) begin errors++; $display("FAIL bp_in_ready k=%0d got=%b want=%b", k, ir_a, k < 2); end
      or_a = 0; iv_a = 1; op_a = 2'b01;
      if (k == 0) begin x1_a = 32'h3F800000; x2_a = 32'h40000000; tag_a = 4'h5; end
      else if (k == 1) begin x1_a = 32'h40000000; x2_a = 32'h3F800000; tag_a = 4'h6; end
      else begin x1_a = 32'h3F800000; x2_a = 32'h40000000; tag_a = 4'h7; end
    end
    @(negedge clk);
    checks++; if ({ov_a, otag_a} !== {1'b1, 4'h5}) begin errors++; $display("FAIL bp_first got v=%b tag=%h want v=1 tag=5", ov_a, otag_a); end
    or_a = 1; iv_a = 0;
    @(negedge clk);
    checks++; if ({ov_a, otag_a, res_a} !== {1'b1, 4'h6, 1'b0}) begin errors++; $display("FAIL bp_second got v=%b tag=%h res=%b want v=1 tag=6 res=0", ov_a, otag_a, res_a); end
    @(negedge clk);
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b want=0", ov_a); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    or_a = 1; iv_a = 1; op_a = 2'b00; x1_a = 32'h3F800000; x2_a = 32'h3F800000; tag_a = 4'h1;
    @(negedge clk);
    tag_a = 4'h2;
    @(negedge clk);
    iv_a = 0;
    checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL mid_in_flight got=%b want=1", ov_a); end
    rstn = 0;
    #1;
    checks++; if ({ov_a, ir_a, otag_a} !== {1'b0, 1'b0, 4'h0}) begin errors++; $display("FAIL mid_async got v=%b rdy=%b tag=%h want v=0 rdy=0 tag=0", ov_a, ir_a, otag_a); end
    @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL mid_stale k=%0d got=%b want=0", k, ov_a); end
      if (k == 0) begin
        checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b want=1", ir_a); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_zero_nan;
    test_reserved;
    test_sweep;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
